instruction_cache_dm: RTL and testbench
=======================================

// Module: instruction_cache_dm
// PURPOSE
//  Direct-mapped, multi-word-line instruction cache between the fetch stage and the unified memory controller.
//  Successor to the 2-entry fetch buffer. Hit returns in 1 cycle; miss refills a whole line word by word.
//  Memory words are byte-reversed into instruction order on refill. fence.i invalidates the whole cache.
// PARAMETERS
//  ADDR_WIDTH      17  byte address width
//  LEN             32  instruction / memory word width
//  BYTE_SIZE       8   bits per byte
//  NUM_LINES       16  cache lines, power of 2, >=2; INDEX_W=$clog2(NUM_LINES)
//  WORDS_PER_LINE  4   words per line, power of 2, >=1; OFFS_W=$clog2(WORDS_PER_LINE)
// PORTS
//  clk                 in   1           clock, rising edge
//  rst                 in   1           asynchronous reset, active-high
//  inst_addr           in   ADDR_WIDTH  fetch byte address; bits[1:0] ignored
//  inst_fetch_enabled  in   1           fetch request, sampled in IDLE
//  flush               in   1           invalidate all lines (fence.i)
//  instruction         out  LEN         fetched instruction, valid while status==`IF_FINISHED
//  inst_fetch_status   out  2           `I_CACHE_RESTING/`I_CACHE_WORKING/`I_CACHE_STALL/`IF_FINISHED
//  mem_data            in   LEN         memory read data, raw byte order
//  mem_status          in   2           `MEM_INST_FINISHED marks mem_data valid
//  mem_vis_addr        out  ADDR_WIDTH  memory word address
//  mem_vis_signal      out  2           `MEM_READ or `MEM_NOP
//  hit_count/miss_count out 32          only with I_CACHE_PERF_EN
// BEHAVIOUR
//  Reset (async): all valid bits 0, state IDLE, instruction=0, status=`I_CACHE_RESTING, mem_vis_addr=0, mem_vis_signal=`MEM_NOP.
//  Address split: offset=addr[OFFS_W+1:2], index=addr[INDEX_W+OFFS_W+1:OFFS_W+2], tag=the remaining upper bits.
//  States: IDLE, REFILL, WAIT, DONE.
//  IDLE: status `I_CACHE_RESTING, `MEM_NOP. When inst_fetch_enabled=1, latch address, then
//   - hit (valid & tag match): next edge drives instruction=data[index][offset], status=`IF_FINISHED for 1 cycle, stays IDLE.
//   - miss: go to REFILL with word counter k=0; next edge status=`I_CACHE_WORKING.
//  REFILL: drive mem_vis_addr=line_base+4k, mem_vis_signal=`MEM_READ; go to WAIT.
//  WAIT: status `I_CACHE_STALL; keep `MEM_READ and the address.
//   - When mem_status==`MEM_INST_FINISHED: write {mem_data[7:0],mem_data[15:8],mem_data[23:16],mem_data[31:24]} into word k.
//   - Then k==WORDS_PER_LINE-1 -> DONE; else k+1 -> REFILL.
//  DONE: write tag, set valid unless a flush arrived during this refill, `MEM_NOP.
//   - Next edge: instruction=requested word, status=`IF_FINISHED, state IDLE.
//  Latency: hit 1 cycle; miss = WORDS_PER_LINE*(2+mem latency)+2 cycles.
//  Request is accepted only in IDLE; inst_fetch_enabled in other states is ignored.
//  Requester drops enable on `IF_FINISHED. If it is still high in the following IDLE cycle, that is a new request.
//  Dropping enable mid-refill does not abort: the line completes and is installed.
//  flush in IDLE: clears all valid bits at the edge; a simultaneous request is treated as a miss.
//  flush in REFILL/WAIT/DONE: clears all valid bits. Current refill completes and returns the instruction, but the line is left invalid.
//  A miss overwrites the indexed line unconditionally; no write-back (read-only cache).
//  Top address line wraps modulo 2^ADDR_WIDTH.
// CONFIGURATION
//  I_CACHE_PERF_EN defined: hit_count/miss_count ports exist.
//   - Each is 32-bit, reset 0, +1 per accepted hit/miss in IDLE, saturates at 32'hFFFFFFFF, not cleared by flush.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  Reset mid-WAIT -> next cycle: status `I_CACHE_RESTING, `MEM_NOP, and a request to the same address misses.
//  Cold fetch 0x00010, mem latency 3 -> reads 0x00010,14,18,1C in order; `IF_FINISHED after 22 cycles.
//   - mem_data 0x11223344 returns instruction 0x44332211.
//  Fetch 0x00014 after that line fill -> `IF_FINISHED next cycle, no `MEM_READ issued.
//  Fetch 0x00010, then 0x00110 (same index, default params), then 0x00010 -> three misses, line evicted each time.
//  flush asserted during WAIT of a 0x00020 refill -> instruction returned; refetch of 0x00020 misses.
//  I_CACHE_PERF_EN: 1 miss then 3 hits in the line -> hit_count=3, miss_count=1; flush leaves counts unchanged.

Source files
------------

// File: rtl/instruction_cache_dm.sv
// ---------------------------------------------------------------------------
// instruction_cache_dm
// Direct-mapped, multi-word-line instruction cache sitting between the fetch
// stage and the unified memory controller. A hit returns the instruction one
// cycle after the request; a miss refills the whole indexed line word by word
// (byte-reversing each memory word into instruction order) and then returns
// the requested word. flush (fence.i) invalidates every line.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   inst_addr           fetch byte address (bits [1:0] ignored)
//   inst_fetch_enabled  fetch request, accepted only while idle
//   flush               invalidate all lines
//   instruction         fetched instruction, valid while status is IF_FINISHED
//   inst_fetch_status   RESTING / WORKING / STALL / IF_FINISHED
//   mem_data            memory read data, raw byte order
//   mem_status          MEM_INST_FINISHED marks mem_data valid
//   mem_vis_addr        memory byte address of the word being read
//   mem_vis_signal      MEM_READ or MEM_NOP
//   hit_count           accepted hits   (only with I_CACHE_PERF_EN)
//   miss_count          accepted misses (only with I_CACHE_PERF_EN)
//
// Optional feature macro: I_CACHE_PERF_EN adds saturating hit/miss counters.
// ---------------------------------------------------------------------------

`ifndef I_CACHE_RESTING
`define I_CACHE_RESTING 2'b00
`endif
`ifndef I_CACHE_WORKING
`define I_CACHE_WORKING 2'b01
`endif
`ifndef I_CACHE_STALL
`define I_CACHE_STALL 2'b10
`endif
`ifndef IF_FINISHED
`define IF_FINISHED 2'b11
`endif
`ifndef MEM_NOP
`define MEM_NOP 2'b00
`endif
`ifndef MEM_READ
`define MEM_READ 2'b01
`endif
`ifndef MEM_INST_FINISHED
`define MEM_INST_FINISHED 2'b10
`endif

module instruction_cache_dm #(
    parameter int unsigned ADDR_WIDTH     = 17,
    parameter int unsigned LEN            = 32,
    parameter int unsigned BYTE_SIZE      = 8,
    parameter int unsigned NUM_LINES      = 16,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic                  inst_fetch_enabled,
    input  logic                  flush,
    output logic [LEN-1:0]        instruction,
    output logic [1:0]            inst_fetch_status,
    input  logic [LEN-1:0]        mem_data,
    input  logic [1:0]            mem_status,
    output logic [ADDR_WIDTH-1:0] mem_vis_addr,
    output logic [1:0]            mem_vis_signal
`ifdef I_CACHE_PERF_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int unsigned INDEX_W   = $clog2(NUM_LINES);
    localparam int unsigned OFFS_W    = $clog2(WORDS_PER_LINE);
    // Word counter / offset need at least one bit even for one-word lines.
    localparam int unsigned CNT_W     = (OFFS_W == 0) ? 1 : OFFS_W;
    localparam int unsigned TAG_W     = ADDR_WIDTH - INDEX_W - OFFS_W - 2;
    localparam int unsigned ENTRY_W   = INDEX_W + OFFS_W;
    localparam int unsigned ENTRIES   = NUM_LINES * WORDS_PER_LINE;
    localparam int unsigned NUM_BYTES = LEN / BYTE_SIZE;
    localparam int unsigned LINE_SH   = OFFS_W + 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REFILL = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Address field helpers
    function automatic logic [INDEX_W-1:0] f_index(input logic [ADDR_WIDTH-1:0] a);
        return INDEX_W'(a >> LINE_SH);
    endfunction

    function automatic logic [CNT_W-1:0] f_offs(input logic [ADDR_WIDTH-1:0] a);
        return CNT_W'((a >> 2) & ADDR_WIDTH'(WORDS_PER_LINE - 1));
    endfunction

    function automatic logic [TAG_W-1:0] f_tag(input logic [ADDR_WIDTH-1:0] a);
        return TAG_W'(a >> (INDEX_W + LINE_SH));
    endfunction

    function automatic logic [ENTRY_W-1:0] f_entry(input logic [INDEX_W-1:0] idx,
                                                   input logic [CNT_W-1:0]   offs);
        return (ENTRY_W'(idx) << OFFS_W) | ENTRY_W'(offs);
    endfunction

    // Line base with word k of that line; OR keeps the address inside the line.
    function automatic logic [ADDR_WIDTH-1:0] f_word_addr(input logic [ADDR_WIDTH-1:0] a,
                                                          input logic [CNT_W-1:0]      k);
        return ((a >> LINE_SH) << LINE_SH) | (ADDR_WIDTH'(k) << 2);
    endfunction

    // Storage
    logic [LEN-1:0]       data_mem_q [ENTRIES];
    logic [TAG_W-1:0]     tag_mem_q  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q, valid_d;

    // Control and output registers
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  flushed_q, flushed_d;
    logic [LEN-1:0]        instruction_q, instruction_d;
    logic [1:0]            status_q, status_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [1:0]            mem_sig_q, mem_sig_d;

    // Array write controls
    logic                  data_we;
    logic [ENTRY_W-1:0]    data_waddr;
    logic                  tag_we;
    logic                  hit_req;
    logic                  miss_req;

    // Lookup of the incoming request and of the latched request
    logic [INDEX_W-1:0]    req_index, cur_index;
    logic [CNT_W-1:0]      req_offs, cur_offs;
    logic [TAG_W-1:0]      req_tag, cur_tag;
    logic                  req_hit;
    logic [LEN-1:0]        swapped;

    assign req_index = f_index(inst_addr);
    assign req_offs  = f_offs(inst_addr);
    assign req_tag   = f_tag(inst_addr);
    assign cur_index = f_index(addr_q);
    assign cur_offs  = f_offs(addr_q);
    assign cur_tag   = f_tag(addr_q);
    assign req_hit   = valid_q[req_index] && (tag_mem_q[req_index] == req_tag);

    // Reverse byte order of the memory word into instruction order
    always_comb begin
        swapped = '0;
        for (int b = 0; b < int'(NUM_BYTES); b++) begin
            swapped[b*BYTE_SIZE +: BYTE_SIZE] = mem_data[(int'(NUM_BYTES) - 1 - b)*BYTE_SIZE +: BYTE_SIZE];
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        flushed_d     = flushed_q;
        instruction_d = instruction_q;
        status_d      = status_q;
        mem_addr_d    = mem_addr_q;
        mem_sig_d     = mem_sig_q;
        valid_d       = valid_q;
        data_we       = 1'b0;
        data_waddr    = f_entry(cur_index, cnt_q);
        tag_we        = 1'b0;
        hit_req       = 1'b0;
        miss_req      = 1'b0;

        if (flush) begin
            valid_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                status_d  = `I_CACHE_RESTING;
                mem_sig_d = `MEM_NOP;
                if (inst_fetch_enabled) begin
                    addr_d = inst_addr;
                    // A flush on the same edge wins over the lookup.
                    if (req_hit && !flush) begin
                        instruction_d = data_mem_q[f_entry(req_index, req_offs)];
                        status_d      = `IF_FINISHED;
                        hit_req       = 1'b1;
                    end else begin
                        state_d    = S_REFILL;
                        cnt_d      = '0;
                        flushed_d  = 1'b0;
                        status_d   = `I_CACHE_WORKING;
                        mem_addr_d = f_word_addr(inst_addr, '0);
                        mem_sig_d  = `MEM_READ;
                        miss_req   = 1'b1;
                    end
                end
            end

            S_REFILL: begin
                state_d  = S_WAIT;
                status_d = `I_CACHE_STALL;
                if (flush) begin
                    flushed_d = 1'b1;
                end
            end

            S_WAIT: begin
                status_d = `I_CACHE_STALL;
                if (flush) begin
                    flushed_d = 1'b1;
                end
                if (mem_status == `MEM_INST_FINISHED) begin
                    data_we = 1'b1;
                    if (cnt_q == CNT_W'(WORDS_PER_LINE - 1)) begin
                        state_d   = S_DONE;
                        mem_sig_d = `MEM_NOP;
                    end else begin
                        cnt_d      = cnt_q + CNT_W'(1);
                        state_d    = S_REFILL;
                        mem_addr_d = f_word_addr(addr_q, cnt_q + CNT_W'(1));
                    end
                end
            end

            S_DONE: begin
                tag_we = 1'b1;
                // A flush seen at any point of this refill leaves the line invalid.
                if (!flushed_q && !flush) begin
                    valid_d[cur_index] = 1'b1;
                end
                instruction_d = data_mem_q[f_entry(cur_index, cur_offs)];
                status_d      = `IF_FINISHED;
                mem_sig_d     = `MEM_NOP;
                state_d       = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            cnt_q         <= '0;
            flushed_q     <= 1'b0;
            instruction_q <= '0;
            status_q      <= `I_CACHE_RESTING;
            mem_addr_q    <= '0;
            mem_sig_q     <= `MEM_NOP;
            valid_q       <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
            flushed_q     <= flushed_d;
            instruction_q <= instruction_d;
            status_q      <= status_d;
            mem_addr_q    <= mem_addr_d;
            mem_sig_q     <= mem_sig_d;
            valid_q       <= valid_d;
        end
    end

    // Data and tag arrays; contents are qualified by valid_q so need no reset
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem_q[data_waddr] <= swapped;
        end
        if (tag_we) begin
            tag_mem_q[cur_index] <= cur_tag;
        end
    end

    assign instruction       = instruction_q;
    assign inst_fetch_status = status_q;
    assign mem_vis_addr      = mem_addr_q;
    assign mem_vis_signal    = mem_sig_q;

`ifdef I_CACHE_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // Saturating counters of accepted requests; flush does not touch them
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit_req && (hit_cnt_q != 32'hFFFF_FFFF)) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (miss_req && (miss_cnt_q != 32'hFFFF_FFFF)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    // Request classification only feeds the optional counters.
    logic unused_req;
    assign unused_req = hit_req ^ miss_req;
`endif

endmodule

// File: tb/tb_instruction_cache_dm.sv
// ---------------------------------------------------------------------------
// tb_instruction_cache_dm
// Scoreboard bench for instruction_cache_dm: expected instructions are pushed
// when a fetch is issued and popped when the cache reports IF_FINISHED. A
// behavioural memory answers each read MEM_LAT+2 cycles after it first appears
// (one REFILL cycle plus MEM_LAT+1 WAIT cycles) and logs every issued address.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

`ifndef I_CACHE_RESTING
`define I_CACHE_RESTING 2'b00
`endif
`ifndef I_CACHE_WORKING
`define I_CACHE_WORKING 2'b01
`endif
`ifndef I_CACHE_STALL
`define I_CACHE_STALL 2'b10
`endif
`ifndef IF_FINISHED
`define IF_FINISHED 2'b11
`endif
`ifndef MEM_NOP
`define MEM_NOP 2'b00
`endif
`ifndef MEM_READ
`define MEM_READ 2'b01
`endif
`ifndef MEM_INST_FINISHED
`define MEM_INST_FINISHED 2'b10
`endif

module tb_instruction_cache_dm;

    localparam int MEM_LAT  = 3;
    localparam int MISS_LAT = 4 * (2 + MEM_LAT) + 2;
    localparam int TIMEOUT  = 300;

    logic        clk;
    logic        rst;
    logic [16:0] inst_addr;
    logic        inst_fetch_enabled;
    logic        flush;
    logic [31:0] instruction;
    logic [1:0]  inst_fetch_status;
    logic [31:0] mem_data;
    logic [1:0]  mem_status;
    logic [16:0] mem_vis_addr;
    logic [1:0]  mem_vis_signal;
`ifdef I_CACHE_PERF_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int total;
    int bad;

    logic [31:0] exp_q[$];
    logic [16:0] read_log[$];

    instruction_cache_dm dut (
        .clk                (clk),
        .rst                (rst),
        .inst_addr          (inst_addr),
        .inst_fetch_enabled (inst_fetch_enabled),
        .flush              (flush),
        .instruction        (instruction),
        .inst_fetch_status  (inst_fetch_status),
        .mem_data           (mem_data),
        .mem_status         (mem_status),
        .mem_vis_addr       (mem_vis_addr),
        .mem_vis_signal     (mem_vis_signal)
`ifdef I_CACHE_PERF_EN
        ,
        .hit_count          (hit_count),
        .miss_count         (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Raw memory contents, memory byte order
    function automatic logic [31:0] raw_word(input logic [16:0] a);
        if (a == 17'h00010) return 32'h11223344;
        return {a[14:0] ^ 15'h2B5D, a};
    endfunction

    function automatic logic [31:0] to_inst(input logic [31:0] r);
        return {r[7:0], r[15:8], r[23:16], r[31:24]};
    endfunction

    // Memory model
    logic        mem_busy;
    logic [16:0] mem_cur;
    int          mem_cnt;
    always @(negedge clk) begin
        mem_status = `MEM_NOP;
        if (rst || mem_vis_signal !== `MEM_READ) begin
            mem_busy = 1'b0;
        end else begin
            if (!mem_busy || mem_vis_addr !== mem_cur) begin
                mem_busy = 1'b1;
                mem_cur  = mem_vis_addr;
                mem_cnt  = 0;
                read_log.push_back(mem_vis_addr);
            end
            mem_cnt++;
            if (mem_cnt == MEM_LAT + 2) begin
                mem_status = `MEM_INST_FINISHED;
                mem_data   = raw_word(mem_cur);
                mem_busy   = 1'b0;
            end
        end
    end

    // One fetch: push expectation, wait for IF_FINISHED, check latency and data.
    // flush_at: cycle (0 = request cycle) in which flush is pulsed, -1 for none.
    task automatic fetch(input logic [16:0] a, input int exp_lat, input int flush_at,
                         input string nm);
        int          cyc;
        logic [31:0] exp;
        @(negedge clk);
        exp_q.push_back(to_inst(raw_word({a[16:2], 2'b00})));
        inst_addr          = a;
        inst_fetch_enabled = 1'b1;
        flush              = (flush_at == 0);
        cyc                = 0;
        do begin
            @(negedge clk);
            cyc++;
            flush = (cyc == flush_at);
            if (cyc == 1 && exp_lat > 1) begin
                total++;
                if (inst_fetch_status !== `I_CACHE_WORKING) begin
                    bad++;
                    $display("FAIL %s_working: status=%0d expected=%0d", nm,
                             inst_fetch_status, `I_CACHE_WORKING);
                end
            end
        end while (inst_fetch_status !== `IF_FINISHED && cyc < TIMEOUT);
        inst_fetch_enabled = 1'b0;
        flush              = 1'b0;
        exp                = exp_q.pop_front();
        total++;
        if (cyc != exp_lat) begin
            bad++;
            $display("FAIL %s_latency: cycles=%0d expected=%0d", nm, cyc, exp_lat);
        end
        total++;
        if (instruction !== exp) begin
            bad++;
            $display("FAIL %s_data: instruction=%h expected=%h", nm, instruction, exp);
        end
    endtask

    task automatic pulse_reset();
        inst_fetch_enabled = 1'b0;
        flush              = 1'b0;
        rst                = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        read_log.delete();
    endtask

    task automatic test_reset();
        pulse_reset();
        total++;
        if (inst_fetch_status !== `I_CACHE_RESTING) begin
            bad++;
            $display("FAIL reset_status: status=%0d expected=%0d", inst_fetch_status, `I_CACHE_RESTING);
        end
        total++;
        if (mem_vis_signal !== `MEM_NOP) begin
            bad++;
            $display("FAIL reset_signal: signal=%0d expected=%0d", mem_vis_signal, `MEM_NOP);
        end
        total++;
        if (mem_vis_addr !== 17'h0) begin
            bad++;
            $display("FAIL reset_addr: addr=%h expected=0", mem_vis_addr);
        end
        total++;
        if (instruction !== 32'h0) begin
            bad++;
            $display("FAIL reset_inst: instruction=%h expected=0", instruction);
        end
    endtask

    task automatic test_cold_miss();
        logic [16:0] exp_a [4];
        exp_a[0] = 17'h00010;
        exp_a[1] = 17'h00014;
        exp_a[2] = 17'h00018;
        exp_a[3] = 17'h0001C;
        read_log.delete();
        fetch(17'h00010, MISS_LAT, -1, "cold");
        total++;
        if (read_log.size() != 4) begin
            bad++;
            $display("FAIL cold_reads: count=%0d expected=4", read_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (read_log[i] !== exp_a[i]) begin
                    bad++;
                    $display("FAIL cold_read%0d: addr=%h expected=%h", i, read_log[i], exp_a[i]);
                end
            end
        end
        total++;
        if (instruction !== 32'h44332211) begin
            bad++;
            $display("FAIL cold_swap: instruction=%h expected=44332211", instruction);
        end
    endtask

    task automatic test_hit();
        read_log.delete();
        fetch(17'h00014, 1, -1, "hit14");
        fetch(17'h0001C, 1, -1, "hit1c");
        fetch(17'h00012, 1, -1, "hit10_low_bits");
        total++;
        if (read_log.size() != 0) begin
            bad++;
            $display("FAIL hit_noread: reads=%0d expected=0", read_log.size());
        end
    endtask

    // Enable held through IF_FINISHED is a second request
    task automatic test_back_to_back();
        logic [31:0] exp;
        @(negedge clk);
        exp_q.push_back(to_inst(raw_word(17'h00014)));
        exp_q.push_back(to_inst(raw_word(17'h00018)));
        inst_addr          = 17'h00014;
        inst_fetch_enabled = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            exp = exp_q.pop_front();
            total++;
            if (inst_fetch_status !== `IF_FINISHED || instruction !== exp) begin
                bad++;
                $display("FAIL b2b_%0d: status=%0d inst=%h expected status=%0d inst=%h", i,
                         inst_fetch_status, instruction, `IF_FINISHED, exp);
            end
            inst_addr = 17'h00018;
            if (i == 1) inst_fetch_enabled = 1'b0;
        end
        @(negedge clk);
        total++;
        if (inst_fetch_status !== `I_CACHE_RESTING) begin
            bad++;
            $display("FAIL b2b_rest: status=%0d expected=%0d", inst_fetch_status, `I_CACHE_RESTING);
        end
    endtask

    task automatic test_evict();
        pulse_reset();
        fetch(17'h00010, MISS_LAT, -1, "evict_a");
        fetch(17'h00110, MISS_LAT, -1, "evict_b");
        fetch(17'h00010, MISS_LAT, -1, "evict_a2");
    endtask

    // Flush together with a request to a valid line forces a miss; line then installs
    task automatic test_flush_idle();
        fetch(17'h00010, MISS_LAT, 0, "flush_idle");
        fetch(17'h00014, 1, -1, "flush_idle_after");
    endtask

    task automatic test_flush_refill();
        fetch(17'h00020, MISS_LAT, 4, "flush_wait");
        fetch(17'h00020, MISS_LAT, -1, "flush_refetch");
        fetch(17'h00024, 1, -1, "flush_reinstalled");
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        inst_addr          = 17'h00040;
        inst_fetch_enabled = 1'b1;
        repeat (4) @(negedge clk);
        inst_fetch_enabled = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        total++;
        if (inst_fetch_status !== `I_CACHE_RESTING) begin
            bad++;
            $display("FAIL midwait_status: status=%0d expected=%0d", inst_fetch_status, `I_CACHE_RESTING);
        end
        total++;
        if (mem_vis_signal !== `MEM_NOP) begin
            bad++;
            $display("FAIL midwait_signal: signal=%0d expected=%0d", mem_vis_signal, `MEM_NOP);
        end
        rst = 1'b0;
        fetch(17'h00040, MISS_LAT, -1, "midwait_refetch");
    endtask

    task automatic test_top_wrap();
        read_log.delete();
        fetch(17'h1FFF8, MISS_LAT, -1, "top_line");
        total++;
        if (read_log.size() != 4 || read_log[0] !== 17'h1FFF0 || read_log[3] !== 17'h1FFFC) begin
            bad++;
            $display("FAIL top_reads: count=%0d first=%h last=%h expected 4 1fff0 1fffc",
                     read_log.size(), read_log[0], read_log[read_log.size()-1]);
        end
        fetch(17'h1FFF4, 1, -1, "top_hit");
    endtask

`ifdef I_CACHE_PERF_EN
    task automatic test_perf();
        pulse_reset();
        fetch(17'h00010, MISS_LAT, -1, "perf_miss");
        fetch(17'h00014, 1, -1, "perf_h1");
        fetch(17'h00018, 1, -1, "perf_h2");
        fetch(17'h0001C, 1, -1, "perf_h3");
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            total++;
            if (hit_count !== 32'd3 || miss_count !== 32'd1) begin
                bad++;
                $display("FAIL perf_counts%0d: hit=%0d miss=%0d expected hit=3 miss=1",
                         pass, hit_count, miss_count);
            end
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
        end
    endtask
`endif

    initial begin
        total              = 0;
        bad                = 0;
        rst                = 1'b1;
        inst_addr          = '0;
        inst_fetch_enabled = 1'b0;
        flush              = 1'b0;
        mem_data           = '0;
        mem_status         = `MEM_NOP;
        mem_busy           = 1'b0;
        mem_cur            = '0;
        mem_cnt            = 0;
        test_reset();
        test_cold_miss();
        test_hit();
        test_back_to_back();
        test_evict();
        test_flush_idle();
        test_flush_refill();
        test_reset_mid_wait();
        test_top_wrap();
`ifdef I_CACHE_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
